// File: rtl/ndp_tile_sequencer_if.sv
// Handshake and operand/result buses between the tile sequencer and its environment.
// No logic and no latency; it only bundles the wires.
// Flow control is carried by start_valid/start_ready and res_valid/res_ready inside the bundle.
interface ndp_tile_sequencer_if #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 64,
    parameter int K_BITS     = 8
);
    localparam int AW = SYS_HEIGHT * ARR_HEIGHT * WIDTH;
    localparam int BW = SYS_WIDTH * ARR_WIDTH * WIDTH;
    localparam int CW = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH;

    logic              start_valid;
    logic              start_ready;
    logic [K_BITS-1:0] start_k;
    logic              a_rd_en;
    logic              b_rd_en;
    logic [K_BITS-1:0] a_rd_addr;
    logic [K_BITS-1:0] b_rd_addr;
    logic [AW-1:0]     a_rd_data;
    logic [BW-1:0]     b_rd_data;
    logic              arr_reset;
    logic [AW-1:0]     arr_in_a;
    logic [BW-1:0]     arr_in_b;
    logic              arr_in_done_flag;
    logic              arr_calc_done_flag;
    logic [CW-1:0]     arr_out_c;
    logic              res_valid;
    logic              res_ready;
    logic [CW-1:0]     res_data;
    logic              busy;
    logic              error;

    // Sequencer side
    modport master (
        input  start_valid, start_k, a_rd_data, b_rd_data, arr_calc_done_flag, arr_out_c, res_ready,
        output start_ready, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_reset, arr_in_a, arr_in_b,
               arr_in_done_flag, res_valid, res_data, busy, error
    );

    // Job source, operand buffers, array and result sink side
    modport slave (
        output start_valid, start_k, a_rd_data, b_rd_data, arr_calc_done_flag, arr_out_c, res_ready,
        input  start_ready, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_reset, arr_in_a, arr_in_b,
               arr_in_done_flag, res_valid, res_data, busy, error
    );
endinterface

// File: rtl/ndp_tile_sequencer.sv
// Job controller for one systolic array: prime reads, feed K operand steps, wait for result, hand it back.
// Latency: accept -> 1 prime cycle -> K feed cycles -> drain until calc_done (or TIMEOUT cycles) -> result.
// Backpressure: start_ready only in IDLE (jobs not queued); result held stable in OUT until res_ready.
module ndp_tile_sequencer #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 64,
    parameter int K_BITS     = 8,
    parameter int TIMEOUT    = 1024
) (
    input logic                  clk,
    input logic                  reset,
    ndp_tile_sequencer_if.master tile
);
    localparam int CW = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FEED,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [K_BITS-1:0] k_q;
    logic [K_BITS-1:0] step_q;
    logic [TW-1:0]     tmo_q;
    logic [CW-1:0]     res_q;
    logic              error_q;
    logic              error_d;

    logic              k_zero;
    logic              feed_last;
    logic              tmo_hit;

    logic              start_rdy;
    logic              arr_rst;
    logic              rd_en;
    logic [K_BITS-1:0] rd_addr;
    logic              in_done;
    logic              res_vld;
    logic              feeding;

    assign k_zero    = (tile.start_k == '0);
    // step_q only reaches k_q-1 inside FEED, so a K of all-ones never wraps the counter
    assign feed_last = (step_q == (k_q - K_BITS'(1)));
    assign tmo_hit   = (tmo_q == TMO_LAST);

    // State, job length, step/timeout counters, captured result and error pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            step_q  <= '0;
            tmo_q   <= '0;
            res_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            if (state_q == S_IDLE && tile.start_valid && !k_zero) begin
                k_q <= tile.start_k;
            end
            step_q <= (state_q == S_FEED)  ? step_q + K_BITS'(1) : '0;
            tmo_q  <= (state_q == S_DRAIN) ? tmo_q + TW'(1)      : '0;
            if (state_q == S_DRAIN && tile.arr_calc_done_flag) begin
                res_q <= tile.arr_out_c;
            end
        end
    end

    // Next state and state-decoded outputs; read for step j+1 overlaps feed of step j
    always_comb begin
        state_d   = state_q;
        error_d   = 1'b0;
        start_rdy = 1'b0;
        arr_rst   = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        in_done   = 1'b0;
        res_vld   = 1'b0;
        feeding   = 1'b0;
        case (state_q)
            S_IDLE: begin
                start_rdy = 1'b1;
                arr_rst   = 1'b1;
                if (tile.start_valid) begin
                    if (k_zero) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                arr_rst = 1'b1;
                rd_en   = 1'b1;
                state_d = S_FEED;
            end
            S_FEED: begin
                feeding = 1'b1;
                if (feed_last) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = step_q + K_BITS'(1);
                end
            end
            S_DRAIN: begin
                in_done = 1'b1;
                // completion wins over a timeout landing on the same cycle
                if (tile.arr_calc_done_flag) begin
                    state_d = S_OUT;
                end else if (tmo_hit) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                in_done = 1'b1;
                res_vld = 1'b1;
                if (tile.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tile.start_ready      = start_rdy;
    assign tile.a_rd_en          = rd_en;
    assign tile.b_rd_en          = rd_en;
    assign tile.a_rd_addr        = rd_addr;
    assign tile.b_rd_addr        = rd_addr;
    assign tile.arr_reset        = arr_rst;
    assign tile.arr_in_a         = feeding ? tile.a_rd_data : '0;
    assign tile.arr_in_b         = feeding ? tile.b_rd_data : '0;
    assign tile.arr_in_done_flag = in_done;
    assign tile.res_valid        = res_vld;
    assign tile.res_data         = res_q;
    assign tile.busy             = (state_q != S_IDLE);
    assign tile.error            = error_q;
endmodule

// File: tb/tb_ndp_tile_sequencer.sv
// Bench for ndp_tile_sequencer: operand-buffer and array models plus a job-timeline reference model.
// Outputs are compared every cycle at the falling edge; inputs change 1-2 time units after the rising edge.
// Directed jobs cover normal run, K=0, K=1, K=255, timeout, held result, and mid-job reset.
module tb_ndp_tile_sequencer;
    localparam int WIDTH = 16, ARR_HEIGHT = 4, ARR_WIDTH = 4, SYS_HEIGHT = 1, SYS_WIDTH = 64;
    localparam int K_BITS = 8, TIMEOUT = 16;
    localparam int NR = SYS_HEIGHT * ARR_HEIGHT;
    localparam int NC = SYS_WIDTH * ARR_WIDTH;
    localparam int AW = NR * WIDTH, BW = NC * WIDTH, CW = NR * NC * WIDTH;

    logic clk = 1'b0;
    logic reset_n;

    ndp_tile_sequencer_if #(
        .WIDTH(WIDTH), .ARR_HEIGHT(ARR_HEIGHT), .ARR_WIDTH(ARR_WIDTH),
        .SYS_HEIGHT(SYS_HEIGHT), .SYS_WIDTH(SYS_WIDTH), .K_BITS(K_BITS)
    ) tile ();

    ndp_tile_sequencer #(
        .WIDTH(WIDTH), .ARR_HEIGHT(ARR_HEIGHT), .ARR_WIDTH(ARR_WIDTH),
        .SYS_HEIGHT(SYS_HEIGHT), .SYS_WIDTH(SYS_WIDTH), .K_BITS(K_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset_n),
        .tile (tile)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual[63:0]=%0h required[63:0]=%0h", name, cyc, act[63:0], exp[63:0]);
        end
    endtask

    // Operand matrices are closed-form per job seed: A[r][j], B[j][c]
    function automatic logic [WIDTH-1:0] a_el(input int s, input int r, input int j);
        return WIDTH'(s * 7 + r * 31 + j * 13 + 1);
    endfunction
    function automatic logic [WIDTH-1:0] b_el(input int s, input int j, input int c);
        return WIDTH'(s * 3 + j * 17 + c * 5 + 2);
    endfunction
    function automatic logic [AW-1:0] a_col(input int s, input int j);
        logic [AW-1:0] v;
        for (int r = 0; r < NR; r++) v[r*WIDTH +: WIDTH] = a_el(s, r, j);
        return v;
    endfunction
    function automatic logic [BW-1:0] b_row(input int s, input int j);
        logic [BW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*WIDTH +: WIDTH] = b_el(s, j, c);
        return v;
    endfunction
    // Reference product C = A @ B, element (r,c) at flat index r*NC+c, wrapping at WIDTH bits
    function automatic logic [CW-1:0] model_c(input int s, input int k);
        logic [CW-1:0]    v;
        logic [WIDTH-1:0] acc;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                acc = '0;
                for (int j = 0; j < k; j++) acc = acc + WIDTH'(a_el(s, r, j) * b_el(s, j, c));
                v[(r*NC+c)*WIDTH +: WIDTH] = acc;
            end
        end
        return v;
    endfunction

    // Job-timeline reference model state
    int            cur_seed   = 0;
    int            done_delay = 6;
    bit            m_job      = 1'b0;
    bit            m_out      = 1'b0;
    bit            m_err      = 1'b0;
    bit            err_next;
    int            m_e, m_k, m_seed, m_dcnt, rel, jj;
    logic [CW-1:0] m_c = '0;

    // Observed statistics for the directed literal checks
    int            rd_cnt, feed_cnt, drain_obs, valid_cnt, busy_cnt, err_cnt, first_done;
    int            addr_q[$];
    logic [AW-1:0] feed2_a;
    logic [CW-1:0] res_snap;

    logic              e_sr, e_busy, e_arst, e_rd, e_done, e_val;
    logic [K_BITS-1:0] e_addr;
    logic [AW-1:0]     e_a;
    logic [BW-1:0]     e_b;

    // Operand buffers: data appears one cycle after a read strobe, junk otherwise
    logic              a_en_s, b_en_s;
    logic [K_BITS-1:0] a_ad_s, b_ad_s;
    initial begin
        tile.a_rd_data = '1;
        tile.b_rd_data = '1;
        forever begin
            @(negedge clk);
            a_en_s = tile.a_rd_en;  a_ad_s = tile.a_rd_addr;
            b_en_s = tile.b_rd_en;  b_ad_s = tile.b_rd_addr;
            @(posedge clk);
            #1;
            tile.a_rd_data = a_en_s ? a_col(cur_seed, int'(a_ad_s)) : '1;
            tile.b_rd_data = b_en_s ? b_row(cur_seed, int'(b_ad_s)) : '1;
        end
    end

    // Array: calc_done one cycle, done_delay cycles after done_flag first rises; result bus churns otherwise
    int          dcnt = 0;
    logic        calc;
    logic [31:0] junk;
    initial begin
        tile.arr_calc_done_flag = 1'b0;
        tile.arr_out_c = '0;
        forever begin
            @(negedge clk);
            dcnt = tile.arr_in_done_flag ? dcnt + 1 : 0;
            @(posedge clk);
            #1;
            calc = (done_delay > 0) && (dcnt == done_delay);
            junk = $urandom | 32'h1;
            tile.arr_calc_done_flag = calc;
            tile.arr_out_c = calc ? m_c : (m_c ^ {(CW/32){junk}});
        end
    end

    // Per-cycle compare against the job timeline, then advance the model across the coming edge
    always @(negedge clk) begin
        e_sr = 1'b1; e_busy = 1'b0; e_arst = 1'b1; e_rd = 1'b0; e_addr = '0;
        e_done = 1'b0; e_val = 1'b0; e_a = '0; e_b = '0; rel = 0;
        if (m_job) begin
            rel = cyc - m_e;
            e_sr = 1'b0; e_busy = 1'b1;
            if (rel == 0) begin
                e_rd = 1'b1;
            end else if (rel <= m_k) begin
                jj = rel - 1;
                e_arst = 1'b0;
                e_a = a_col(m_seed, jj);
                e_b = b_row(m_seed, jj);
                if (jj < m_k - 1) begin
                    e_rd = 1'b1;
                    e_addr = K_BITS'(jj + 1);
                end
            end else begin
                e_arst = 1'b0; e_done = 1'b1; e_val = m_out;
            end
        end
        check("start_ready", tile.start_ready, e_sr);
        check("busy", tile.busy, e_busy);
        check("arr_reset", tile.arr_reset, e_arst);
        check("a_rd_en", tile.a_rd_en, e_rd);
        check("b_rd_en", tile.b_rd_en, e_rd);
        check("in_done_flag", tile.arr_in_done_flag, e_done);
        check("res_valid", tile.res_valid, e_val);
        check("error", tile.error, m_err);
        if (e_rd) begin
            check("a_rd_addr", tile.a_rd_addr, e_addr);
            check("b_rd_addr", tile.b_rd_addr, e_addr);
        end
        check_w("arr_in_a", tile.arr_in_a, e_a);
        check_w("arr_in_b", tile.arr_in_b, e_b);
        if (e_val) check_w("res_data", tile.res_data, m_c);

        if (tile.a_rd_en) begin
            rd_cnt++;
            addr_q.push_back(int'(tile.a_rd_addr));
        end
        if (tile.busy && !tile.arr_reset && !tile.arr_in_done_flag) begin
            if (feed_cnt == 2) feed2_a = tile.arr_in_a;
            feed_cnt++;
        end
        if (tile.arr_in_done_flag && !tile.res_valid) drain_obs++;
        if (tile.arr_in_done_flag && first_done < 0) first_done = cyc - m_e;
        if (tile.res_valid) begin
            valid_cnt++;
            res_snap = tile.res_data;
        end
        if (tile.busy) busy_cnt++;
        if (tile.error) err_cnt++;

        err_next = 1'b0;
        if (!reset_n) begin
            m_job = 1'b0;
        end else if (!m_job) begin
            if (tile.start_valid) begin
                if (tile.start_k == '0) begin
                    err_next = 1'b1;
                end else begin
                    m_job = 1'b1; m_e = cyc + 1; m_k = int'(tile.start_k);
                    m_seed = cur_seed; m_out = 1'b0; m_dcnt = 0;
                    m_c = model_c(m_seed, m_k);
                end
            end
        end else if (rel > m_k && !m_out) begin
            if (tile.arr_calc_done_flag) begin
                m_out = 1'b1;
            end else begin
                m_dcnt++;
                if (m_dcnt == TIMEOUT) begin
                    m_job = 1'b0;
                    err_next = 1'b1;
                end
            end
        end else if (m_out && tile.res_ready) begin
            m_job = 1'b0;
        end
        m_err = err_next;
    end

    task automatic clear_stats();
        @(posedge clk);
        #2;
        rd_cnt = 0; feed_cnt = 0; drain_obs = 0; valid_cnt = 0; busy_cnt = 0; err_cnt = 0;
        first_done = -1; feed2_a = '0; res_snap = '0;
        addr_q.delete();
    endtask

    task automatic do_start(input int k);
        @(posedge clk);
        #2;
        tile.start_valid = 1'b1;
        tile.start_k = K_BITS'(k);
        @(posedge clk);
        #2;
        tile.start_valid = 1'b0;
        tile.start_k = '0;
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!tile.busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle cyc=%0d actual=busy required=idle within %0d cycles", cyc, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        tile.start_valid = 1'b0;
        tile.start_k = '0;
        tile.res_ready = 1'b1;
        first_done = -1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst start_ready", tile.start_ready, 1'b1);
        check("rst arr_reset", tile.arr_reset, 1'b1);
        check("rst busy", tile.busy, 1'b0);
        check("rst res_valid", tile.res_valid, 1'b0);
        check("rst a_rd_en", tile.a_rd_en, 1'b0);
        check_w("rst res_data", tile.res_data, '0);

        // K=5 job, array answers 6 cycles after done_flag
        cur_seed = 0; done_delay = 6;
        clear_stats();
        do_start(5);
        wait_idle(200);
        check("t1 rd_cnt", rd_cnt, 5);
        for (int i = 0; i < addr_q.size(); i++) check("t1 addr_seq", addr_q[i], i);
        check("t1 feed2 a r0", feed2_a[15:0], 27);
        check("t1 feed2 a r1", feed2_a[31:16], 58);
        check("t1 busy_cnt", busy_cnt, 14);
        check("t1 valid_cnt", valid_cnt, 1);
        check("t1 c00", res_snap[15:0], 7070);
        check("t1 c11", res_snap[(1*NC+1)*WIDTH +: WIDTH], 14100);
        check("t1 err_cnt", err_cnt, 0);

        // Illegal K=0
        clear_stats();
        do_start(0);
        repeat (3) @(negedge clk);
        check("t2 err_cnt", err_cnt, 1);
        check("t2 rd_cnt", rd_cnt, 0);
        check("t2 busy_cnt", busy_cnt, 0);

        // K=1 and K=255
        cur_seed = 1;
        clear_stats();
        do_start(1);
        wait_idle(100);
        check("t3 k1 first_done", first_done, 2);
        check("t3 k1 feed_cnt", feed_cnt, 1);
        check("t3 k1 rd_cnt", rd_cnt, 1);
        cur_seed = 3;
        clear_stats();
        do_start(255);
        wait_idle(600);
        check("t3 k255 first_done", first_done, 256);
        check("t3 k255 feed_cnt", feed_cnt, 255);
        check("t3 k255 rd_cnt", rd_cnt, 255);
        check("t3 k255 valid_cnt", valid_cnt, 1);

        // Timeout: array never answers
        cur_seed = 4; done_delay = -1;
        clear_stats();
        do_start(2);
        wait_idle(100);
        check("t4 err_cnt", err_cnt, 1);
        check("t4 drain_cycles", drain_obs, 16);
        check("t4 valid_cnt", valid_cnt, 0);
        check("t4 busy", tile.busy, 1'b0);
        check("t4 start_ready", tile.start_ready, 1'b1);

        // Result held for 10 cycles; a start request during OUT must be ignored
        cur_seed = 5; done_delay = 6;
        tile.res_ready = 1'b0;
        clear_stats();
        do_start(3);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (tile.res_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t5 res_valid seen", seen, 1'b1);
        end
        @(posedge clk);
        #2;
        tile.start_valid = 1'b1;
        tile.start_k = K_BITS'(7);
        repeat (8) @(posedge clk);
        #2;
        tile.start_valid = 1'b0;
        tile.start_k = '0;
        @(posedge clk);
        #2 tile.res_ready = 1'b1;
        wait_idle(50);
        check("t5 valid_cnt", valid_cnt, 11);
        check("t5 rd_cnt", rd_cnt, 3);
        check("t5 err_cnt", err_cnt, 0);

        // Reset during FEED j=2 of a K=5 job, then a clean K=3 job
        cur_seed = 6;
        clear_stats();
        do_start(5);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("t6 arr_reset", tile.arr_reset, 1'b1);
        check("t6 a_rd_en", tile.a_rd_en, 1'b0);
        check("t6 busy", tile.busy, 1'b0);
        check("t6 error", tile.error, 1'b0);
        repeat (3) @(negedge clk);
        check("t6 err_cnt", err_cnt, 0);
        cur_seed = 7;
        clear_stats();
        do_start(3);
        wait_idle(100);
        check("t6 valid_cnt", valid_cnt, 1);
        check("t6 rd_cnt", rd_cnt, 3);
        for (int i = 0; i < addr_q.size(); i++) check("t6 addr_seq", addr_q[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
